// File: rtl/pwm_velocity_decoder.sv
// PWM/direction to signed velocity decoder: measures ena duty over a 256-tick window
// and inverts the motor driver's scaling. Optional 2-tap output filter: PWM_VEL_DEC_FILTER_EN.
module pwm_velocity_decoder #(
  parameter int PRESCALE = 4
) (
  input  logic       cclk,
  input  logic       rstb,
  input  logic       ena_in,
  input  logic       dir_in,
  output logic [7:0] velocity,
  output logic       vel_valid,
  output logic       dir_err
);

  logic       ena_q, ena_s, dir_q, dir_s;
  logic [7:0] tick_cnt;
  logic [7:0] sample_cnt;
  logic [8:0] high_cnt;
  logic       win_dir, have_dir, err_flag;

  logic       tick, win_end;
  logic [8:0] high_nxt;
  logic       win_dir_nxt, err_nxt;
  logic [7:0] duty;
  logic [6:0] mag;
  logic [7:0] result, out_nxt;

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      ena_q <= 1'b0;
      ena_s <= 1'b0;
      dir_q <= 1'b0;
      dir_s <= 1'b0;
    end else begin
      ena_q <= ena_in;
      ena_s <= ena_q;
      dir_q <= dir_in;
      dir_s <= dir_q;
    end
  end

  always_ff @(posedge cclk) begin
    if (!rstb) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 8'd1;
  end

  // The sample taken on the window-end tick is folded into this window's result.
  always_comb begin
    tick        = (tick_cnt == 8'(PRESCALE - 1));
    win_end     = tick && (sample_cnt == 8'hFF);
    high_nxt    = high_cnt + {8'd0, ena_s};
    win_dir_nxt = (ena_s && !have_dir) ? dir_s : win_dir;
    err_nxt     = err_flag | (ena_s && have_dir && (dir_s != win_dir));
    duty        = high_nxt[8] ? 8'hFF : high_nxt[7:0];
    mag         = duty[7:1];
    if (high_nxt == 9'd0) result = 8'h00;
    else if (win_dir_nxt) result = {1'b0, mag};
    else                  result = ~{1'b0, mag};
  end

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      sample_cnt <= '0;
      high_cnt   <= '0;
      win_dir    <= 1'b0;
      have_dir   <= 1'b0;
      err_flag   <= 1'b0;
    end else if (tick) begin
      if (win_end) begin
        sample_cnt <= '0;
        high_cnt   <= '0;
        have_dir   <= 1'b0;
        err_flag   <= 1'b0;
      end else begin
        sample_cnt <= sample_cnt + 8'd1;
        high_cnt   <= high_nxt;
        win_dir    <= win_dir_nxt;
        have_dir   <= have_dir | ena_s;
        err_flag   <= err_nxt;
      end
    end
  end

`ifdef PWM_VEL_DEC_FILTER_EN
  logic       primed;
  logic [8:0] sum;

  // First window after reset loads directly so the reset zero never biases the average.
  always_comb begin
    sum     = {velocity[7], velocity} + {result[7], result};
    out_nxt = primed ? sum[8:1] : result;
  end

  always_ff @(posedge cclk) begin
    if (!rstb)        primed <= 1'b0;
    else if (win_end) primed <= 1'b1;
  end
`else
  assign out_nxt = result;
`endif

  always_ff @(posedge cclk) begin
    if (!rstb) begin
      velocity  <= 8'h00;
      vel_valid <= 1'b0;
      dir_err   <= 1'b0;
    end else begin
      vel_valid <= win_end;
      if (win_end) begin
        velocity <= out_nxt;
        dir_err  <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_velocity_decoder.sv
// Scoreboard bench for pwm_velocity_decoder at PRESCALE=4 (1024-cycle windows).
module tb_pwm_velocity_decoder;
  localparam int P   = 4;
  localparam int WIN = 256 * P;

  logic       cclk = 1'b0;
  logic       rstb = 1'b0;
  logic       ena_in = 1'b0;
  logic       dir_in = 1'b0;
  logic [7:0] velocity;
  logic       vel_valid;
  logic       dir_err;

  always #5 cclk = ~cclk;

  pwm_velocity_decoder #(.PRESCALE(P)) dut (
    .cclk(cclk), .rstb(rstb), .ena_in(ena_in), .dir_in(dir_in),
    .velocity(velocity), .vel_valid(vel_valid), .dir_err(dir_err)
  );

  typedef struct { logic [7:0] vel; logic err; } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic do_reset();
    @(negedge cclk);
    rstb = 1'b0;
    @(negedge cclk);
    @(negedge cclk);
  endtask

  // Window w drives ena high for the first hi cycles; dir is d0 before offset flip, d1 after,
  // or toggles every cycle when tog is set. Window 0 uses hi0, later windows hi1.
  task automatic run_pattern(input string name, input int nwin, input int hi0, input int hi1,
                             input logic d0, input logic d1, input int flip, input bit tog,
                             input exp_t e0, input exp_t e1);
    sb.delete();
    sb.push_back(e0);
    for (int w = 1; w < nwin; w++) sb.push_back(e1);
    do_reset();
    fork
      begin
        for (int c = 0; c < nwin * WIN; c++) begin
          int w, o;
          w = c / WIN;
          o = c % WIN;
          rstb   = 1'b1;
          ena_in = (o < ((w == 0) ? hi0 : hi1));
          dir_in = tog ? c[0] : ((o < flip) ? d0 : d1);
          @(negedge cclk);
        end
      end
      begin
        int budget;
        exp_t e;
        budget = nwin * WIN + 8;
        while (sb.size() > 0 && budget > 0) begin
          @(negedge cclk);
          budget--;
          if (vel_valid === 1'b1) begin
            e = sb.pop_front();
            n_tests++;
            if (velocity !== e.vel || dir_err !== e.err) begin
              n_fail++;
              $display("FAIL %s: velocity=%h dir_err=%b, expected velocity=%h dir_err=%b",
                       name, velocity, dir_err, e.vel, e.err);
            end
          end
        end
        if (sb.size() > 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_timeout: %0d windows not reported, expected 0", name, sb.size());
        end
      end
    join
  endtask

  task automatic test_reset();
    rstb = 1'b0; ena_in = 1'b1; dir_in = 1'b1;
    repeat (3) @(negedge cclk);
    n_tests++;
    if (velocity !== 8'h00) begin n_fail++; $display("FAIL reset_velocity: got %h, expected 00", velocity); end
    n_tests++;
    if (vel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vel_valid: got %b, expected 0", vel_valid); end
    n_tests++;
    if (dir_err !== 1'b0) begin n_fail++; $display("FAIL reset_dir_err: got %b, expected 0", dir_err); end
  endtask

  task automatic test_full_forward();
    run_pattern("full_fwd", 2, WIN, WIN, 1'b1, 1'b1, WIN, 1'b0, '{8'h7F, 1'b0}, '{8'h7F, 1'b0});
  endtask

  task automatic test_full_reverse();
    run_pattern("full_rev", 2, WIN, WIN, 1'b0, 1'b0, WIN, 1'b0, '{8'h80, 1'b0}, '{8'h80, 1'b0});
  endtask

  task automatic test_half_forward();
    run_pattern("half_fwd", 2, 512, 512, 1'b1, 1'b1, WIN, 1'b0, '{8'h40, 1'b0}, '{8'h40, 1'b0});
  endtask

  task automatic test_quarter_reverse();
    run_pattern("quarter_rev", 2, 256, 256, 1'b0, 1'b0, WIN, 1'b0, '{8'hDF, 1'b0}, '{8'hDF, 1'b0});
  endtask

  // Outputs must hold between pulses.
  task automatic test_hold();
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge cclk);
      if (vel_valid !== 1'b0 || velocity !== 8'hDF || dir_err !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: %0d cycles changed (last velocity=%h), expected 0", bad, velocity);
    end
  endtask

  task automatic test_idle_dir_toggle();
    run_pattern("idle_toggle", 2, 0, 0, 1'b0, 1'b0, WIN, 1'b1, '{8'h00, 1'b0}, '{8'h00, 1'b0});
  endtask

  // dir flips 1->0 at cycle 400 of each window, first seen at sample 100.
  task automatic test_dir_flip();
    run_pattern("dir_flip", 2, WIN, WIN, 1'b1, 1'b0, 400, 1'b0, '{8'h7F, 1'b1}, '{8'h7F, 1'b1});
  endtask

  task automatic test_back_to_back();
    exp_t e1;
`ifdef PWM_VEL_DEC_FILTER_EN
    e1 = '{8'h30, 1'b0};
`else
    e1 = '{8'h20, 1'b0};
`endif
    run_pattern("back_to_back", 2, 512, 256, 1'b1, 1'b1, WIN, 1'b0, '{8'h40, 1'b0}, e1);
  endtask

  task automatic test_reset_mid_window();
    int pulses = 0;
    int cnt;
    do_reset();
    for (int c = 0; c < WIN + 800; c++) begin
      rstb = 1'b1; ena_in = 1'b1; dir_in = 1'b1;
      @(negedge cclk);
      if (vel_valid === 1'b1) pulses++;
    end
    n_tests++;
    if (pulses != 1 || velocity !== 8'h7F) begin
      n_fail++;
      $display("FAIL pre_reset: pulses=%0d velocity=%h, expected 1 and 7f", pulses, velocity);
    end
    rstb = 1'b0;
    @(negedge cclk);
    rstb = 1'b1;
    n_tests++;
    if (velocity !== 8'h00 || vel_valid !== 1'b0 || dir_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: velocity=%h vel_valid=%b dir_err=%b, expected 00 0 0",
               velocity, vel_valid, dir_err);
    end
    // Counts cycles from the reset cycle itself to the cycle vel_valid is high.
    cnt = 1;
    while (vel_valid !== 1'b1 && cnt < 2000) begin
      @(negedge cclk);
      cnt++;
    end
    n_tests++;
    if (cnt != WIN + 1) begin
      n_fail++;
      $display("FAIL mid_reset_latency: got %0d cycles, expected %0d", cnt, WIN + 1);
    end
    n_tests++;
    if (velocity !== 8'h7F || dir_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_value: velocity=%h dir_err=%b, expected 7f 0", velocity, dir_err);
    end
  endtask

  initial begin
    test_reset();
    test_full_forward();
    test_full_reverse();
    test_half_forward();
    test_quarter_reverse();
    test_hold();
    test_idle_dir_toggle();
    test_dir_flip();
    test_back_to_back();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_velocity_decoder.md
Name: pwm_velocity_decoder

Overview:
- Receive-side counterpart of the motor PWM driver: takes the ena (PWM) and dir pins and rebuilds the signed 8-bit velocity word that produced them.
- Used for loopback self-test of the motor path and for monitoring external H-bridge command lines.
- Measures duty cycle over a fixed sampling window and inverts the driver's scaling:
  - dir=1: duty = v<<1
  - dir=0: duty = (~v)<<1

Parameters:
- PRESCALE, 4: cclk cycles per sample tick. Window = 256 ticks = 256*PRESCALE cycles. Legal range 1..255.

Ports:
- cclk  input  1  system clock, rising edge
- rstb  input  1  reset, synchronous, active-low
- ena_in  input  1  PWM line, asynchronous to the decoder
- dir_in  input  1  direction line, asynchronous
- velocity  output  8  decoded signed velocity, two's complement, -128..127
- vel_valid  output  1  one-cycle pulse when velocity updates
- dir_err  output  1  direction changed during last window; updated with vel_valid

Behaviour:
- Reset (rstb=0 at posedge cclk):
  - velocity=0, vel_valid=0, dir_err=0.
  - Synchronizers, tick counter, sample counter, high counter and direction latch all cleared.
  - Reset mid-window discards the partial window; the first window after reset starts at the first cycle with rstb=1.
- Input sync: ena_in and dir_in each pass through a 2-flop synchronizer. All logic below uses the synchronized values (ena_s, dir_s). Latency from input to ena_s is 2 cycles.
- Tick generator:
  - Counter 0..PRESCALE-1, wraps.
  - tick asserts on the cycle the counter equals PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- Sampling state, updated on tick only:
  - sample_cnt: 8 bits, counts 0..255.
  - high_cnt: 9 bits, 0..256; increments when ena_s=1.
  - First tick in the window with ena_s=1: latch dir_s into win_dir and set have_dir.
  - Later ticks with ena_s=1 and dir_s != win_dir: set err_flag (sticky within the window).
- Window end (tick with sample_cnt=255, the sample taken on that tick included):
  - duty = high_cnt saturated to 255 (256 maps to 255).
  - mag = duty>>1 (7 bits).
  - If high_cnt=0: result = 0x00.
  - Else if win_dir=1: result = {1'b0, mag}.
  - Else: result = ~{1'b0, mag}, giving 0x80..0xFF.
  - On the cycle after the window-end tick: velocity=result, dir_err=err_flag, vel_valid=1 for exactly one cycle.
  - Counters, have_dir and err_flag clear on the window-end tick. The next window begins with the following tick; there are no gaps between windows.
- Input-to-output latency: last sample of a window to vel_valid is 1 cycle, plus 2 synchronizer cycles.
- When dir_err=1, velocity still reports the result computed with the first-latched direction.
- velocity and dir_err hold between vel_valid pulses.
- dir_s is ignored whenever ena_s=0.

Optional Feature:
- Macro: PWM_VEL_DEC_FILTER_EN.
- Defined:
  - Output is a 2-tap average: velocity_next = (velocity_prev + result) >>> 1, using a 9-bit signed sum and arithmetic shift (floor toward -inf).
  - The first window after reset loads result directly, with no averaging against the reset value 0.
  - Each window's result still uses the unfiltered decode.
- Undefined: velocity = result directly, as in Behaviour. No filter registers are present.

Test Plan (all cases use PRESCALE=4, window 1024 cycles):
- ena_in=1 constant, dir_in=1, 2 full windows → second vel_valid shows velocity=0x7F, dir_err=0.
- ena_in=1 constant, dir_in=0 → velocity=0x80 (-128), dir_err=0.
- ena_in square wave 512 cycles high / 512 low aligned to the window, dir_in=1 → 128 high samples, velocity=0x40 (+64).
- ena_in 256 high / 768 low, dir_in=0 → 64 high samples, velocity=0xDF (-33); matches the driver encoding of -33 giving duty 64.
- ena_in=0 constant, dir_in toggling → velocity=0x00, dir_err=0. Then ena_in=1 with dir_in flipped 1→0 at sample 100 → velocity=0x7F, dir_err=1.
- Drop rstb for 1 cycle at sample 200 of a window → no vel_valid for that window, velocity=0 after reset, next vel_valid exactly 1024+1 cycles after rstb rises. With PWM_VEL_DEC_FILTER_EN: windows decoding +64 then +32 → outputs 0x40 then 0x30.
